// File: rtl/rgb_chroma_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rgb_norm_pkg
// Description : Shared types and width helpers for the chromaticity
//               normaliser. It holds the FSM state enum and the sum, output
//               and divider-step widths, derived from CH/IW/FW.
// Config      : CHROMA_ROUND_EN adds one extra quotient bit so the result
//               can be rounded half-up. When it is undefined, the result is
//               truncated.
// Revision    : 1.0 - initial release
// ============================================================================
package rgb_norm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

`ifdef CHROMA_ROUND_EN
  localparam int C_ROUND_BITS = 1;
`else
  localparam int C_ROUND_BITS = 0;
`endif

  // Channel-sum width: the sum of CH samples of IW bits never overflows this.
  function automatic int sw_f(input int iw, input int ch);
    return iw + $clog2(ch);
  endfunction

  // Output word width: 2.FW unsigned fixed point.
  function automatic int ow_f(input int fw);
    return fw + 2;
  endfunction

  // Quotient bits produced per channel. This is one cycle per bit.
  function automatic int d_f(input int fw);
    return fw + 1 + C_ROUND_BITS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_chroma_norm_if.sv
`default_nettype none
// ============================================================================
// Module      : rgb_chroma_norm_if
// Description : Pixel-in / result-out bus for rgb_chroma_norm.
// Ports       : IN_VALID/IN_READY/IN_PIX carry the input pixel handshake.
//               OUT_VALID/OUT_READY/OUT_PIX/out_norm/out_zero carry the
//               result handshake.
//               The slave modport is the normaliser's view.
//               The master modport is the source/sink view.
// Revision    : 1.0 - initial release
// ============================================================================
interface rgb_chroma_norm_if
  import rgb_norm_pkg::*;
#(
  parameter int CH = 3,
  parameter int IW = 8,
  parameter int FW = 16
);
  localparam int OW = ow_f(FW);

  logic               IN_VALID;
  logic               IN_READY;
  logic [CH*IW-1:0]   IN_PIX;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic [CH*IW-1:0]   OUT_PIX;
  logic [CH*OW-1:0]   out_norm;
  logic               out_zero;

  modport slave (
    input  IN_VALID, IN_PIX, OUT_READY,
    output IN_READY, OUT_VALID, OUT_PIX, out_norm, out_zero
  );

  modport master (
    output IN_VALID, IN_PIX, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_PIX, out_norm, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/rgb_chroma_norm_div.sv
`default_nettype none
// ============================================================================
// Module      : rgb_frac_divider
// Description : Restoring fractional divider. It computes num/den with num<=den
//               and produces one quotient bit per cycle over D cycles.
//               A start pulse loads a new operation. A start pulse also takes
//               priority in the cycle where done is high, so back-to-back
//               channels lose no cycles. quo is combinational and is valid
//               while done is high.
// Ports       : CLK, RST_N (async, active-low)
//               start : load num and begin dividing
//               num   : numerator (SW bits)
//               den   : divisor (SW bits), must be held stable while busy
//               done  : last quotient bit is being produced this cycle
//               quo   : 2.FW result (OW bits)
// Config      : CHROMA_ROUND_EN rounds the D-bit quotient half-up by dropping
//               its extra LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_frac_divider #(
  parameter int SW = 10,
  parameter int D  = 17,
  parameter int OW = 18
) (
  input  wire           CLK,
  input  wire           RST_N,
  input  wire           start,
  input  wire  [SW-1:0] num,
  input  wire  [SW-1:0] den,
  output logic          done,
  output logic [OW-1:0] quo
);
  localparam int CW = $clog2(D);

  logic [SW:0]   r_rem;
  logic [D-2:0]  r_q;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [SW:0]   w_trial;
  logic          w_bit;
  logic [SW:0]   w_rem_nx;
  logic [D-1:0]  w_qfull;

  // Step 0 compares the numerator itself, which yields the integer bit.
  // Later steps compare the doubled remainder. The remainder stays below den,
  // so the doubled remainder fits in SW+1 bits.
  always_comb begin
    w_trial  = (r_cnt == '0) ? r_rem : {r_rem[SW-1:0], 1'b0};
    w_bit    = (w_trial >= {1'b0, den});
    w_rem_nx = w_bit ? (w_trial - {1'b0, den}) : w_trial;
    w_qfull  = {r_q, w_bit};
    done     = r_busy && (r_cnt == CW'(D - 1));
  end

`ifdef CHROMA_ROUND_EN
  // (q+1)>>1 is written as q>>1 plus the dropped LSB.
  assign quo = {1'b0, w_qfull[D-1:1]} + {{(OW-1){1'b0}}, w_qfull[0]};
`else
  assign quo = {1'b0, w_qfull};
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_rem  <= {1'b0, num};
      r_q    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_rem  <= w_rem_nx;
      r_q    <= w_qfull[D-2:0];
      r_cnt  <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/rgb_chroma_norm.sv
`default_nettype none
// ============================================================================
// Module      : rgb_chroma_norm
// Description : Chromaticity normaliser. It accepts one CH-channel pixel and
//               returns each channel divided by the channel sum, in 2.FW
//               unsigned fixed point. It also returns the raw samples.
//               A single shared iterative divider processes the channels in
//               turn.
// Ports       : CLK   : clock, rising edge
//               RST_N : asynchronous active-low reset
//               bus   : rgb_chroma_norm_if.slave, which carries the pixel-in
//                       and result-out valid/ready handshakes, OUT_PIX,
//                       out_norm and out_zero
// Config      : CHROMA_ROUND_EN selects round-half-up results (FW+2 divider
//               steps). When it is undefined, results are truncated
//               (FW+1 steps).
// Revision    : 1.0 - initial release
// ============================================================================
module rgb_chroma_norm
  import rgb_norm_pkg::*;
#(
  parameter int CH = 3,
  parameter int IW = 8,
  parameter int FW = 16
) (
  input  wire              CLK,
  input  wire              RST_N,
  rgb_chroma_norm_if.slave bus
);
  localparam int SW = sw_f(IW, CH);
  localparam int OW = ow_f(FW);
  localparam int D  = d_f(FW);
  localparam int KW = $clog2(CH);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CH*IW-1:0] r_pix;
  logic [CH*OW-1:0] r_norm;
  logic             r_zero;
  logic [KW-1:0]    r_k;

  logic [SW-1:0]    w_sum;
  logic [IW-1:0]    w_num;
  int               w_idx;
  logic             w_last;
  logic             w_start;
  logic             w_done;
  logic [OW-1:0]    w_quo;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < CH; i++) begin
      w_sum = w_sum + SW'(r_pix[i*IW +: IW]);
    end
  end

  // The numerator fed to the divider is for the channel being started.
  // That is channel 0 from SUM, or the channel after r_k when a division
  // finishes in DIV.
  always_comb begin
    w_idx  = (r_state == ST_SUM) ? 0 : int'(r_k) + 1;
    w_last = (int'(r_k) == CH - 1);
    w_num  = '0;
    for (int i = 0; i < CH; i++) begin
      if (i == w_idx) begin
        w_num = r_pix[i*IW +: IW];
      end
    end
    w_start = ((r_state == ST_SUM) && (w_sum != '0)) ||
              ((r_state == ST_DIV) && w_done && !w_last);
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (bus.IN_VALID)       w_state_nx = ST_SUM;
      ST_SUM:  w_state_nx = (w_sum == '0) ? ST_OUT : ST_DIV;
      ST_DIV:  if (w_done && w_last)   w_state_nx = ST_OUT;
      ST_OUT:  if (bus.OUT_READY)      w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  rgb_frac_divider #(
    .SW (SW),
    .D  (D),
    .OW (OW)
  ) u_div (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (w_start),
    .num   (SW'(w_num)),
    .den   (w_sum),
    .done  (w_done),
    .quo   (w_quo)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_pix   <= '0;
      r_norm  <= '0;
      r_zero  <= 1'b0;
      r_k     <= '0;
    end else begin
      r_state <= w_state_nx;
      case (r_state)
        ST_IDLE: begin
          if (bus.IN_VALID) begin
            r_pix <= bus.IN_PIX;
          end
        end
        ST_SUM: begin
          r_k <= '0;
          if (w_sum == '0) begin
            r_norm <= '0;
            r_zero <= 1'b1;
          end else begin
            r_zero <= 1'b0;
          end
        end
        ST_DIV: begin
          if (w_done) begin
            for (int i = 0; i < CH; i++) begin
              if (i == int'(r_k)) begin
                r_norm[i*OW +: OW] <= w_quo;
              end
            end
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // RST_N masks IN_READY, so nothing is accepted while reset is held.
  assign bus.IN_READY  = (r_state == ST_IDLE) && RST_N;
  assign bus.OUT_VALID = (r_state == ST_OUT);
  assign bus.OUT_PIX   = r_pix;
  assign bus.out_norm  = r_norm;
  assign bus.out_zero  = r_zero;
endmodule
`default_nettype wire
